dmem_initiator: RTL and testbench
=================================

# dmem_initiator

Single-outstanding requester that drives the byte-addressed, 16-bit data memory port (enable, wr, addr, data_in, data_out) on behalf of the pipeline MEM stage. It accepts load/store requests on a valid/ready handshake and inserts a programmable number of wait cycles ahead of each memory access. It performs exactly one memory access per request, never read and write in the same cycle, and returns a response on a second valid/ready handshake.

## Interface
- ADDR_WIDTH, 16, byte-address width; bit 0 selects the byte within a 16-bit word.
- WAIT_CYCLES, 0, idle cycles inserted before the access cycle; legal range 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a clk edge.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  16  store data.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  16  load data; 0 for stores and errors.
- rsp_wr  out  1  echo of the captured req_wr.
- rsp_err  out  1  misaligned access; only with the alignment check compiled in.
- mem_enable  out  1  to memory enable.
- mem_wr  out  1  to memory wr.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_data_in  out  16  to memory data_in.
- mem_data_out  in  16  from memory data_out; combinational read.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On accept, capture wr, addr, and wdata into the request register.
  - Next state is WAIT when WAIT_CYCLES>0; the wait counter loads WAIT_CYCLES-1.
  - Next state is ACCESS when WAIT_CYCLES=0.
- WAIT: counter decrements each cycle. Move to ACCESS when the counter is 0.
- ACCESS: lasts exactly one cycle.
  - Drives mem_enable=1, mem_wr=captured wr, mem_addr=captured addr, mem_data_in=captured wdata.
  - Loads register mem_data_out into rsp_rdata at the closing edge. Stores load 0.
  - Next state is RESP.
- RESP: rsp_valid=1, with rsp_rdata, rsp_wr, rsp_err stable.
  - On rsp_ready the FSM returns to IDLE.
  - If req_valid is also high in that cycle, the new request is accepted in the same cycle. req_ready = rsp_ready in RESP.
- WAIT and ACCESS: req_ready=0.
- Outside ACCESS: mem_enable=0, mem_wr=0, mem_addr=0, mem_data_in=0.
- Exactly one memory access per accepted request. No retries.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_wr=0, rsp_err=0, busy=0, all mem_* outputs 0, wait counter 0.
- Let cycle 0 be the cycle in which the accept edge occurs.
  - ACCESS occupies cycle 1+WAIT_CYCLES.
  - rsp_valid rises in cycle 2+WAIT_CYCLES.
- Maximum throughput is one request per 2+WAIT_CYCLES cycles, reached when rsp_ready is held high.
- A store is written at the edge that closes ACCESS.
- rsp_valid may stay high indefinitely. Response fields must not change while rsp_valid=1 and rsp_ready=0.
- rst has priority in every state and aborts the operation in flight with no response.
  - rst asserted in ACCESS drops the outputs at that edge. Because the memory is reset from the same rst, no store commits.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - An accepted request with addr[0]=1 skips WAIT and ACCESS.
  - The FSM goes IDLE -> RESP with rsp_err=1 and rsp_rdata=0, and memory is never enabled.
- DMEM_ALIGN_CHECK_EN undefined:
  - mem_addr[0] is forced to 0 and the access proceeds normally.
  - rsp_err is tied to 0.

## Structure
- dmem_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, RESP), 2 bits;
  - the WAIT_CNT_W=4 constant;
  - the request struct (wr, addr, wdata).
- One sub-module, dmem_wait_ctr: load, decrement, and a zero flag for the wait counter. Everything else lives in dmem_initiator.

## Test plan
- Reset check: after rst, all outputs equal their reset values and req_ready=1.
- Load: WAIT_CYCLES=0, memory word at 0x0010 = 0xBEEF, load request for 0x0010.
  - mem_enable=1 and mem_wr=0 in cycle 1 only.
  - rsp_valid=1 with rsp_rdata=0xBEEF in cycle 2.
- Store then load: WAIT_CYCLES=3.
  - Store 0x1234 to 0x0020: one mem_enable&mem_wr cycle, in cycle 4.
  - A following load of 0x0020 returns 0x1234 with rsp_wr=0.
- Backpressure and back-to-back: hold rsp_ready=0 for 3 cycles, with a second request pending.
  - rsp_valid and rsp_rdata stay stable and req_ready=0 throughout.
  - In the cycle rsp_ready rises, the second request is accepted.
- Misaligned load of 0x0011:
  - With DMEM_ALIGN_CHECK_EN: rsp_err=1, rsp_rdata=0, and mem_enable never asserts.
  - Without it: mem_addr=0x0010 and rsp_err=0.
- Reset in WAIT: WAIT_CYCLES=5, assert rst in cycle 2.
  - No mem_enable and no rsp_valid afterwards; busy=0 and req_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory initiator.
package dmem_pkg;

    // Width of the wait-cycle counter (WAIT_CYCLES is 0..15)
    localparam int WAIT_CNT_W = 4;

    // Byte-address width carried in the request register
    localparam int DMEM_ADDR_W = 16;

    // Initiator FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_e;

    // Captured request: direction, byte address and store data
    typedef struct packed {
        logic                   wr;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [15:0]            wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_wait_ctr.sv
// dmem_wait_ctr: loadable down-counter that times the idle cycles ahead of a memory access.
module dmem_wait_ctr
    import dmem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  zero_o
);

    logic [WAIT_CNT_W-1:0] count_q;

    // Load takes priority over decrement; the counter parks at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - WAIT_CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/dmem_initiator.sv
// dmem_initiator: single-outstanding load/store requester for the 16-bit data memory port.
// Optional feature: define DMEM_ALIGN_CHECK_EN to answer odd byte addresses with rsp_err
// instead of accessing memory. Without it, address bit 0 is cleared and the access proceeds.
// ADDR_WIDTH must match DMEM_ADDR_W because the request register type is shared package-wide.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DMEM_ADDR_W,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [15:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [15:0]           rsp_rdata_o,
    output logic                  rsp_wr_o,
    output logic                  rsp_err_o,
    output logic                  mem_enable_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [15:0]           mem_data_in_o,
    input  logic [15:0]           mem_data_out_i,
    output logic                  busy_o
);

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        HAS_WAIT ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    dmem_state_e           state_q;
    dmem_req_t             req_q;
    dmem_req_t             req_in;
    logic                  rsp_valid_q;
    logic [15:0]           rsp_rdata_q;
    logic                  rsp_wr_q;
    logic                  rsp_err_q;
    logic                  mem_enable_q;
    logic                  mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [15:0]           mem_data_in_q;
    logic                  accept;
    logic                  misaligned;
    logic                  ctr_load;
    logic                  ctr_zero;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = req_addr_i[0];
`else
    assign misaligned = 1'b0;
`endif

    assign req_in = '{wr: req_wr_i, addr: req_addr_i, wdata: req_wdata_i};

    // A finishing response frees the slot in the same cycle, so RESP forwards rsp_ready
    assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign ctr_load    = accept && HAS_WAIT && !misaligned;

    dmem_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (state_q == WAIT),
        .zero_o     (ctr_zero)
    );

    // Request/response FSM; memory strobes are registered so they are high only in ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_wr_q      <= 1'b0;
            rsp_err_q     <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
        end else begin
            mem_enable_q  <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;

            case (state_q)
                IDLE: begin
                end
                WAIT: begin
                    if (ctr_zero) begin
                        state_q       <= ACCESS;
                        mem_enable_q  <= 1'b1;
                        mem_wr_q      <= req_q.wr;
                        mem_addr_q    <= req_q.addr & WORD_MASK;
                        mem_data_in_q <= req_q.wdata;
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= req_q.wr ? 16'h0000 : mem_data_out_i;
                    rsp_wr_q    <= req_q.wr;
                    rsp_err_q   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A new request overrides the idle/return path decided above
            if (accept) begin
                req_q <= req_in;
                if (misaligned) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_wr_q    <= req_wr_i;
                    rsp_err_q   <= 1'b1;
                end else if (HAS_WAIT) begin
                    state_q <= WAIT;
                end else begin
                    state_q       <= ACCESS;
                    mem_enable_q  <= 1'b1;
                    mem_wr_q      <= req_wr_i;
                    mem_addr_q    <= req_addr_i & WORD_MASK;
                    mem_data_in_q <= req_wdata_i;
                end
            end
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_wr_o      = rsp_wr_q;
    assign rsp_err_o     = rsp_err_q;
    assign mem_enable_o  = mem_enable_q;
    assign mem_wr_o      = mem_wr_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_in_o = mem_data_in_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: directed bench for dmem_initiator with WAIT_CYCLES = 0, 3 and 5,
// each instance attached to its own small word memory.
module tb_dmem_initiator;

    localparam int WV [3] = '{0, 3, 5};

    logic        clk;
    logic        rst;
    logic        req_valid   [3];
    logic        req_ready   [3];
    logic        req_wr      [3];
    logic [15:0] req_addr    [3];
    logic [15:0] req_wdata   [3];
    logic        rsp_valid   [3];
    logic        rsp_ready   [3];
    logic [15:0] rsp_rdata   [3];
    logic        rsp_wr      [3];
    logic        rsp_err     [3];
    logic        mem_enable  [3];
    logic        mem_wr      [3];
    logic [15:0] mem_addr    [3];
    logic [15:0] mem_data_in [3];
    logic [15:0] mem_data_out[3];
    logic        busy        [3];
    logic        pre_we      [3];
    logic [7:0]  pre_idx;
    logic [15:0] pre_data;

    int nvec = 0;
    int nmis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] mem [0:255];

        dmem_initiator #(.ADDR_WIDTH(16), .WAIT_CYCLES(WV[g])) u_dut (
            .clk            (clk),
            .rst            (rst),
            .req_valid_i    (req_valid[g]),
            .req_ready_o    (req_ready[g]),
            .req_wr_i       (req_wr[g]),
            .req_addr_i     (req_addr[g]),
            .req_wdata_i    (req_wdata[g]),
            .rsp_valid_o    (rsp_valid[g]),
            .rsp_ready_i    (rsp_ready[g]),
            .rsp_rdata_o    (rsp_rdata[g]),
            .rsp_wr_o       (rsp_wr[g]),
            .rsp_err_o      (rsp_err[g]),
            .mem_enable_o   (mem_enable[g]),
            .mem_wr_o       (mem_wr[g]),
            .mem_addr_o     (mem_addr[g]),
            .mem_data_in_o  (mem_data_in[g]),
            .mem_data_out_i (mem_data_out[g]),
            .busy_o         (busy[g])
        );

        // Combinational read, write at the rising edge; reset blocks any write
        assign mem_data_out[g] = mem[mem_addr[g][8:1]];

        always @(posedge clk) begin
            if (pre_we[g]) mem[pre_idx] <= pre_data;
            else if (!rst && mem_enable[g] && mem_wr[g]) mem[mem_addr[g][8:1]] <= mem_data_in[g];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input int k, input logic [15:0] byte_addr, input logic [15:0] data);
        pre_idx  = byte_addr[8:1];
        pre_data = data;
        pre_we[k] = 1'b1;
        tick();
        pre_we[k] = 1'b0;
    endtask

    task automatic drive_req(input int k, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        req_valid[k] = 1'b1;
        req_wr[k]    = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if ({req_ready[k], rsp_valid[k], rsp_wr[k], rsp_err[k], busy[k], mem_enable[k], mem_wr[k]} !== 7'b1000000) begin
                nmis++;
                $display("[TB] FAIL reset_flags inst%0d: got %b expected 1000000", k,
                         {req_ready[k], rsp_valid[k], rsp_wr[k], rsp_err[k], busy[k], mem_enable[k], mem_wr[k]});
            end
            nvec++;
            if ({rsp_rdata[k], mem_addr[k], mem_data_in[k]} !== 48'h0) begin
                nmis++;
                $display("[TB] FAIL reset_data inst%0d: got %h expected 0", k,
                         {rsp_rdata[k], mem_addr[k], mem_data_in[k]});
            end
        end
    endtask

    task automatic test_load();
        preload(0, 16'h0010, 16'hBEEF);
        drive_req(0, 1'b0, 16'h0010, 16'h0000);
        nvec++;
        if (req_ready[0] !== 1'b1) begin nmis++; $display("[TB] FAIL load_ready: got %b expected 1", req_ready[0]); end
        tick();
        req_valid[0] = 1'b0;
        nvec++;
        if ({mem_enable[0], mem_wr[0], rsp_valid[0], busy[0]} !== 4'b1001) begin
            nmis++; $display("[TB] FAIL load_cyc1_strobes: got %b expected 1001", {mem_enable[0], mem_wr[0], rsp_valid[0], busy[0]});
        end
        nvec++;
        if (mem_addr[0] !== 16'h0010) begin nmis++; $display("[TB] FAIL load_cyc1_addr: got %h expected 0010", mem_addr[0]); end
        tick();
        nvec++;
        if ({mem_enable[0], rsp_valid[0], rsp_wr[0], rsp_err[0]} !== 4'b0100) begin
            nmis++; $display("[TB] FAIL load_cyc2_flags: got %b expected 0100", {mem_enable[0], rsp_valid[0], rsp_wr[0], rsp_err[0]});
        end
        nvec++;
        if (rsp_rdata[0] !== 16'hBEEF) begin nmis++; $display("[TB] FAIL load_rdata: got %h expected beef", rsp_rdata[0]); end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        nvec++;
        if ({rsp_valid[0], busy[0]} !== 2'b00) begin nmis++; $display("[TB] FAIL load_release: got %b expected 00", {rsp_valid[0], busy[0]}); end
    endtask

    task automatic test_store_load();
        drive_req(1, 1'b1, 16'h0020, 16'h1234);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) req_valid[1] = 1'b0;
            nvec++;
            if ((mem_enable[1] && mem_wr[1]) !== (c == 4)) begin
                nmis++; $display("[TB] FAIL store_strobe_cyc%0d: got %b expected %b", c, mem_enable[1] && mem_wr[1], c == 4);
            end
            if (c == 4) begin
                nvec++;
                if ({mem_addr[1], mem_data_in[1]} !== 32'h0020_1234) begin
                    nmis++; $display("[TB] FAIL store_addr_data: got %h expected 00201234", {mem_addr[1], mem_data_in[1]});
                end
            end
        end
        nvec++;
        if ({rsp_valid[1], rsp_wr[1], rsp_rdata[1]} !== {2'b11, 16'h0000}) begin
            nmis++; $display("[TB] FAIL store_rsp: got %h expected 30000", {rsp_valid[1], rsp_wr[1], rsp_rdata[1]});
        end
        rsp_ready[1] = 1'b1;
        drive_req(1, 1'b0, 16'h0020, 16'h0000);
        tick();
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        nvec++;
        if ({rsp_valid[1], rsp_wr[1], rsp_rdata[1]} !== {2'b10, 16'h1234}) begin
            nmis++; $display("[TB] FAIL store_then_load: got %h expected 21234", {rsp_valid[1], rsp_wr[1], rsp_rdata[1]});
        end
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        preload(0, 16'h0030, 16'hA5A5);
        preload(0, 16'h0032, 16'h5A5A);
        drive_req(0, 1'b0, 16'h0030, 16'h0000);
        tick();
        drive_req(0, 1'b0, 16'h0032, 16'h0000);
        nvec++;
        if (req_ready[0] !== 1'b0) begin nmis++; $display("[TB] FAIL b2b_access_ready: got %b expected 0", req_ready[0]); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            nvec++;
            if ({rsp_valid[0], req_ready[0], rsp_rdata[0]} !== {2'b10, 16'hA5A5}) begin
                nmis++; $display("[TB] FAIL b2b_stall_cyc%0d: got %h expected 2a5a5", c, {rsp_valid[0], req_ready[0], rsp_rdata[0]});
            end
        end
        tick();
        rsp_ready[0] = 1'b1;
        #1;
        nvec++;
        if (req_ready[0] !== 1'b1) begin nmis++; $display("[TB] FAIL b2b_ready_follow: got %b expected 1", req_ready[0]); end
        tick();
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
        nvec++;
        if ({mem_enable[0], rsp_valid[0], mem_addr[0]} !== {2'b10, 16'h0032}) begin
            nmis++; $display("[TB] FAIL b2b_second_access: got %h expected 20032", {mem_enable[0], rsp_valid[0], mem_addr[0]});
        end
        tick();
        nvec++;
        if ({rsp_valid[0], rsp_rdata[0]} !== {1'b1, 16'h5A5A}) begin
            nmis++; $display("[TB] FAIL b2b_second_rsp: got %h expected 15a5a", {rsp_valid[0], rsp_rdata[0]});
        end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_misaligned();
        logic saw_enable;
        saw_enable = 1'b0;
        drive_req(0, 1'b0, 16'h0011, 16'h0000);
        tick();
        req_valid[0] = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        saw_enable = saw_enable | mem_enable[0];
        nvec++;
        if ({rsp_valid[0], rsp_err[0], rsp_rdata[0]} !== {2'b11, 16'h0000}) begin
            nmis++; $display("[TB] FAIL misalign_err_rsp: got %h expected 30000", {rsp_valid[0], rsp_err[0], rsp_rdata[0]});
        end
        tick();
        saw_enable = saw_enable | mem_enable[0];
        nvec++;
        if (saw_enable !== 1'b0) begin nmis++; $display("[TB] FAIL misalign_no_enable: got %b expected 0", saw_enable); end
`else
        nvec++;
        if ({mem_enable[0], mem_addr[0]} !== {1'b1, 16'h0010}) begin
            nmis++; $display("[TB] FAIL misalign_addr: got %h expected 10010", {mem_enable[0], mem_addr[0]});
        end
        tick();
        nvec++;
        if ({rsp_valid[0], rsp_err[0], rsp_rdata[0]} !== {2'b10, 16'hBEEF}) begin
            nmis++; $display("[TB] FAIL misalign_rsp: got %h expected 2beef", {rsp_valid[0], rsp_err[0], rsp_rdata[0]});
        end
`endif
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        drive_req(2, 1'b1, 16'h0040, 16'hCAFE);
        tick();
        req_valid[2] = 1'b0;
        tick();
        nvec++;
        if (busy[2] !== 1'b1) begin nmis++; $display("[TB] FAIL rstwait_busy_before: got %b expected 1", busy[2]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if ({busy[2], req_ready[2]} !== 2'b01) begin
            nmis++; $display("[TB] FAIL rstwait_idle: got %b expected 01", {busy[2], req_ready[2]});
        end
        for (int c = 0; c < 8; c++) begin
            nvec++;
            if ({mem_enable[2], rsp_valid[2]} !== 2'b00) begin
                nmis++; $display("[TB] FAIL rstwait_quiet_%0d: got %b expected 00", c, {mem_enable[2], rsp_valid[2]});
            end
            tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        pre_idx  = '0;
        pre_data = '0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_wr[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            rsp_ready[k] = 1'b0;
            pre_we[k]    = 1'b0;
        end
        $display("[TB] starting dmem_initiator directed tests");
        test_reset();
        test_load();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
